go_scan: RTL and testbench

//  Sequential win/draw detector for the 3x3 board. On a start pulse it reads the

---
 rtl/go_scan_if.sv | 23 ++
 rtl/go_scan.sv | 187 ++++++++++++++++++
 tb/tb_go_scan.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/go_scan_if.sv
// Control and board-read bundle for the 3x3 win/draw scanner.
// The game-controller / board-store side uses master; the scanner uses slave.
interface go_scan_if;
  logic       start;
  logic       clr;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic       busy;
  logic       done;
  logic [9:0] gameover;
  logic [1:0] winner;

  modport master (
    output start, clr, rd_data,
    input  rd_en, rd_addr, busy, done, gameover, winner
  );

  modport slave (
    input  start, clr, rd_data,
    output rd_en, rd_addr, busy, done, gameover, winner
  );
endinterface

// File: rtl/go_scan.sv
// Sequential win/draw detector for the 3x3 board. Reads nine cells over a
// synchronous read port, checks one line per cycle, then publishes a held
// 10-bit gameover vector and the winner code.
module go_scan #(
  parameter logic [1:0]  X_CODE     = 2'b01,
  parameter logic [1:0]  O_CODE     = 2'b10,
  parameter int unsigned RD_LATENCY = 1
) (
  input logic     clk,
  input logic     rstn,
  go_scan_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StCheck, StDone} state_e;

  localparam logic [3:0] Lat      = 4'(RD_LATENCY);
  localparam logic [3:0] LastRead = Lat + 4'd8;

  state_e          r_state, w_state_next;
  logic [3:0]      r_cnt, w_cnt_next;
  logic [8:0][1:0] r_cell;
  logic [7:0]      r_acc;
  logic [1:0]      r_acc_winner;
  logic            r_done;
  logic [9:0]      r_gameover;
  logic [1:0]      r_winner;

  logic       w_rd_en;
  logic [3:0] w_rd_addr;
  logic [3:0] w_cap_idx;
  logic [3:0] w_i0, w_i1, w_i2;
  logic [1:0] w_a, w_b, w_c;
  logic       w_line_win;
  logic       w_full;
  logic       w_draw;
  logic       w_accept;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; clr overrides every state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = StRead;
          w_cnt_next   = 4'd0;
        end
      end
      StRead: begin
        if (r_cnt == LastRead) begin
          w_state_next = StCheck;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      StCheck: begin
        if (r_cnt == 4'd7) begin
          w_state_next = StDone;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (bus.clr) begin
      w_state_next = StIdle;
      w_cnt_next   = 4'd0;
    end
  end

  // Read strobe and cell address; cell k sits at {k/3, k%3}.
  always_comb begin
    w_rd_en   = (r_state == StRead) && (r_cnt < 4'd9);
    w_rd_addr = 4'h0;
    if (w_rd_en) begin
      case (r_cnt)
        4'd0:    w_rd_addr = 4'h0;
        4'd1:    w_rd_addr = 4'h1;
        4'd2:    w_rd_addr = 4'h2;
        4'd3:    w_rd_addr = 4'h4;
        4'd4:    w_rd_addr = 4'h5;
        4'd5:    w_rd_addr = 4'h6;
        4'd6:    w_rd_addr = 4'h8;
        4'd7:    w_rd_addr = 4'h9;
        4'd8:    w_rd_addr = 4'ha;
        default: w_rd_addr = 4'h0;
      endcase
    end
  end

  // Cell indices of the line under test (rows, cols, diag, anti-diag).
  always_comb begin
    w_i0 = 4'd0;
    w_i1 = 4'd0;
    w_i2 = 4'd0;
    case (r_cnt[2:0])
      3'd0: begin w_i0 = 4'd0; w_i1 = 4'd1; w_i2 = 4'd2; end
      3'd1: begin w_i0 = 4'd3; w_i1 = 4'd4; w_i2 = 4'd5; end
      3'd2: begin w_i0 = 4'd6; w_i1 = 4'd7; w_i2 = 4'd8; end
      3'd3: begin w_i0 = 4'd0; w_i1 = 4'd3; w_i2 = 4'd6; end
      3'd4: begin w_i0 = 4'd1; w_i1 = 4'd4; w_i2 = 4'd7; end
      3'd5: begin w_i0 = 4'd2; w_i1 = 4'd5; w_i2 = 4'd8; end
      3'd6: begin w_i0 = 4'd0; w_i1 = 4'd4; w_i2 = 4'd8; end
      3'd7: begin w_i0 = 4'd2; w_i1 = 4'd4; w_i2 = 4'd6; end
      default: begin w_i0 = 4'd0; w_i1 = 4'd0; w_i2 = 4'd0; end
    endcase
  end

  // Line-win test and board-full test (2'b11 counts as empty).
  always_comb begin
    w_a        = r_cell[w_i0];
    w_b        = r_cell[w_i1];
    w_c        = r_cell[w_i2];
    w_line_win = (w_a == w_b) && (w_b == w_c) && ((w_a == X_CODE) || (w_a == O_CODE));
    w_full     = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (!((r_cell[k] == X_CODE) || (r_cell[k] == O_CODE))) w_full = 1'b0;
    end
    w_draw    = w_full && (r_acc == 8'h00);
    w_cap_idx = r_cnt - Lat;
    w_accept  = (r_state == StIdle) && bus.start && !bus.clr;
  end

  // Capture returned cell codes RD_LATENCY cycles after each strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cell <= '0;
    end else if ((r_state == StRead) && (r_cnt >= Lat)) begin
      r_cell[w_cap_idx] <= bus.rd_data;
    end
  end

  // Accumulate winning lines; the first win found fixes the winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc        <= 8'h00;
      r_acc_winner <= 2'b00;
    end else if (bus.clr || w_accept) begin
      r_acc        <= 8'h00;
      r_acc_winner <= 2'b00;
    end else if ((r_state == StCheck) && w_line_win) begin
      r_acc[r_cnt[2:0]] <= 1'b1;
      if (r_acc_winner == 2'b00) r_acc_winner <= w_a;
    end
  end

  // Publish results on leaving DONE; they hold until the next scan or clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_done     <= 1'b0;
      r_gameover <= 10'h000;
      r_winner   <= 2'b00;
    end else if (bus.clr) begin
      r_done     <= 1'b0;
      r_gameover <= 10'h000;
      r_winner   <= 2'b00;
    end else if (r_state == StDone) begin
      r_done     <= 1'b1;
      r_gameover <= {(|r_acc) | w_draw, w_draw, r_acc};
      r_winner   <= r_acc_winner;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign bus.rd_en    = w_rd_en;
  assign bus.rd_addr  = w_rd_addr;
  assign bus.busy     = (r_state != StIdle);
  assign bus.done     = r_done;
  assign bus.gameover = r_gameover;
  assign bus.winner   = r_winner;

endmodule

// File: tb/tb_go_scan.sv
// Scoreboard bench for go_scan: scans push expected results, a monitor pops
// and compares whenever done is presented.
module tb_go_scan;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  go_scan_if bus ();

  go_scan #(
    .X_CODE    (2'b01),
    .O_CODE    (2'b10),
    .RD_LATENCY(1)
  ) u_dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] go;
    logic [1:0] win;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  logic [1:0] mem[16];
  int         cyc    = 0;
  int         rd_cnt = 0;
  int         n_vec  = 0;
  int         n_err  = 0;

  // Board store with one-cycle synchronous read.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (bus.rd_en) rd_cnt <= rd_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    logic [1:0] c[9];
    c = '{c0, c1, c2, c3, c4, c5, c6, c7, c8};
    for (int i = 0; i < 16; i++) mem[i] = 2'b00;
    for (int k = 0; k < 9; k++) mem[(k / 3) * 4 + (k % 3)] = c[k];
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = q.pop_front();
          check("done_latency", cyc, e.cyc);
          check("gameover", 32'(bus.gameover), 32'(e.go));
          check("winner", 32'(bus.winner), 32'(e.win));
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("scan_timeout", q.size(), 0);
  endtask

  // One scan; extra>0 re-pulses start in that cycle of the scan.
  task automatic scan(input logic [9:0] go, input logic [1:0] win, input int extra);
    exp_t e;
    int   rd0;
    @(negedge clk);
    e.go  = go;
    e.win = win;
    e.cyc = cyc + 20;
    q.push_back(e);
    rd0       = rd_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (extra > 0) begin
      repeat (extra - 1) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_drain();
    check("rd_en_cycles", rd_cnt - rd0, 9);
    repeat (3) @(negedge clk);
    check("hold_gameover", 32'(bus.gameover), 32'(go));
    check("hold_winner", 32'(bus.winner), 32'(win));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    check({tag, "_gameover"}, 32'(bus.gameover), 0);
    check({tag, "_winner"}, 32'(bus.winner), 0);
  endtask

  task automatic stimulus();
    exp_t e;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Row 0 for X, two O's.
    load(1, 1, 1, 0, 2, 2, 0, 0, 0);
    scan(10'h201, 2'b01, 0);
    // O owns col 2 and anti-diagonal.
    load(0, 0, 2, 0, 2, 2, 2, 0, 2);
    scan(10'h2a0, 2'b10, 0);
    // Illegal board: O row 0 and X row 2, winner from lowest index.
    load(2, 2, 2, 0, 0, 0, 1, 1, 1);
    scan(10'h205, 2'b10, 0);
    // X column 1.
    load(0, 1, 0, 2, 1, 2, 0, 1, 0);
    scan(10'h210, 2'b01, 0);
    // Full board with a win is not a draw.
    load(1, 1, 1, 2, 2, 1, 2, 1, 2);
    scan(10'h201, 2'b01, 0);
    // Draw, then the same board with one cell 2'b11.
    load(1, 2, 1, 1, 2, 2, 2, 1, 1);
    scan(10'h300, 2'b00, 0);
    load(1, 2, 1, 1, 3, 2, 2, 1, 1);
    scan(10'h000, 2'b00, 0);
    // Start re-pulsed in cycle 5 is ignored.
    load(1, 2, 1, 1, 2, 2, 2, 1, 1);
    scan(10'h300, 2'b00, 5);
    repeat (25) @(negedge clk);

    // clr in cycle 12 of a scan holding an old 10'h201 result.
    load(1, 1, 1, 0, 2, 2, 0, 0, 0);
    scan(10'h201, 2'b01, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_clr_busy", 32'(bus.busy), 1);
    check("pre_clr_gameover", 32'(bus.gameover), 32'h201);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("clr_gameover", 32'(bus.gameover), 0);
    check("clr_winner", 32'(bus.winner), 0);
    check("clr_busy", 32'(bus.busy), 0);
    check("clr_rd_en", 32'(bus.rd_en), 0);
    repeat (30) @(negedge clk);
    // clr and start together.
    bus.start = 1'b1;
    bus.clr   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    check("clr_start_busy", 32'(bus.busy), 0);
    check("clr_start_rd_en", 32'(bus.rd_en), 0);
    repeat (30) @(negedge clk);

    // Async reset in READ after a nonzero result.
    load(2, 2, 2, 0, 1, 1, 0, 0, 0);
    scan(10'h201, 2'b10, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_read_rd_en", 32'(bus.rd_en), 1);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);

    // start held high: back-to-back scans 20 edges apart.
    load(1, 2, 1, 1, 2, 2, 2, 1, 1);
    @(negedge clk);
    e.go  = 10'h300;
    e.win = 2'b00;
    e.cyc = cyc + 20;
    q.push_back(e);
    e.cyc = cyc + 40;
    q.push_back(e);
    bus.start = 1'b1;
    repeat (25) @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (25) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
